tile_sram_writer: RTL

- Framebuffer write/read arbiter sitting directly downstream of the tile scheduler and rasterizer.
- On each stream trigger it copies one completed tileDim x tileDim colour tile (selected by tile ID) into external 16-bit async SRAM at the tile's screen offset.
- It interleaves single-word scanout reads requested by the VGA colour path.
- It reports completion through a level doneStreaming; the scheduler edge-detects it.

---
 rtl/tile_sram_writer_if.sv | 42 ++++
 rtl/tile_sram_writer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tile_sram_writer_if.sv
`default_nettype none
// =====================================================================
// tile_sram_writer_if : stream control, tile data, scanout read request
// and SRAM strobe bundle for tile_sram_writer            | rev 1.0
// =====================================================================
interface tile_sram_writer_if #(
  parameter int TILE_DIM = 8
);
  logic        streamTileTrigger;
  logic        streamingTileID;
  logic [9:0]  xOffset;
  logic [9:0]  yOffset;
  logic        frameSel;
  logic [15:0] cBufferTile0 [TILE_DIM][TILE_DIM];
  logic [15:0] cBufferTile1 [TILE_DIM][TILE_DIM];
  logic        queueRead;
  logic [19:0] framebufferAddress;
  logic [15:0] DataFromSRAM;
  logic        DataReady;
  logic        doneStreaming;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N;
  logic        SRAM_OE_N;
  logic        SRAM_WE_N;
  logic        SRAM_UB_N;
  logic        SRAM_LB_N;

  modport master (
    output streamTileTrigger, streamingTileID, xOffset, yOffset, frameSel,
    output cBufferTile0, cBufferTile1, queueRead, framebufferAddress,
    input  DataFromSRAM, DataReady, doneStreaming,
    input  SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
  );

  modport slave (
    input  streamTileTrigger, streamingTileID, xOffset, yOffset, frameSel,
    input  cBufferTile0, cBufferTile1, queueRead, framebufferAddress,
    output DataFromSRAM, DataReady, doneStreaming,
    output SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
  );
endinterface
`default_nettype wire

// File: rtl/tile_sram_writer.sv
`default_nettype none
// =====================================================================
// tile_sram_writer : copies one colour tile into async SRAM, with
// single-word scanout reads interleaved at pixel boundaries | rev 1.0
// =====================================================================
module tile_sram_writer #(
  parameter int TILE_DIM    = 8,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int FRAME_WORDS = 307200
) (
  input  wire                BOARD_CLK,
  input  wire                RESET_N,
  tile_sram_writer_if.slave  bus,
  inout  wire  [15:0]        SRAM_DQ
);

  localparam int            CW   = $clog2(TILE_DIM);
  localparam logic [CW-1:0] LAST = CW'(TILE_DIM - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_SETUP   = 3'd1,
    WR_PULSE   = 3'd2,
    RD_ADDR    = 3'd3,
    RD_CAPTURE = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] px, py;
  logic          tile_id;
  logic [9:0]    x_off, y_off;
  logic          frame_sel;
  logic          pending;
  logic [19:0]   rd_addr;
  logic [19:0]   sram_addr;
  logic [15:0]   dq_out;
  logic          dq_oe;
  logic          clip_q;
  logic          we_n, oe_n;
  logic          done;
  logic          data_ready;
  logic [15:0]   data_q;

  logic [CW-1:0] nxt_x, nxt_y, tx, ty;
  logic          last_pix;
  logic          rd_req;
  logic [19:0]   rd_sel_addr;
  logic [9:0]    txo, tyo;
  logic          tfs, tid;
  logic [10:0]   sx, sy;
  logic          t_clip;
  logic [19:0]   t_addr;
  logic [15:0]   t_data;

  // The "target" pixel is the one whose address/data get registered onto
  // the SRAM pins at the end of this cycle: pixel 0 of a new stream when
  // idle, the resumed pixel after a read, otherwise the next pixel.
  always_comb begin
    nxt_x       = (px == LAST) ? '0 : px + 1'b1;
    nxt_y       = (px == LAST) ? py + 1'b1 : py;
    last_pix    = (px == LAST) && (py == LAST);
    rd_req      = pending | bus.queueRead;
    rd_sel_addr = bus.queueRead ? bus.framebufferAddress : rd_addr;
    tx  = nxt_x;
    ty  = nxt_y;
    txo = x_off;
    tyo = y_off;
    tfs = frame_sel;
    tid = tile_id;
    case (state)
      IDLE: begin
        tx  = '0;
        ty  = '0;
        txo = bus.xOffset;
        tyo = bus.yOffset;
        tfs = bus.frameSel;
        tid = bus.streamingTileID;
      end
      RD_ADDR, RD_CAPTURE: begin
        tx = px;
        ty = py;
      end
      default: ;
    endcase
    sx     = {1'b0, txo} + {{(11-CW){1'b0}}, tx};
    sy     = {1'b0, tyo} + {{(11-CW){1'b0}}, ty};
    t_clip = (32'(sx) >= 32'(SCREEN_W)) || (32'(sy) >= 32'(SCREEN_H));
    t_addr = 20'((tfs ? 32'(FRAME_WORDS) : 32'd0) + 32'(sy) * 32'(SCREEN_W) + 32'(sx));
    t_data = tid ? bus.cBufferTile1[tx][ty] : bus.cBufferTile0[tx][ty];
  end

  always_ff @(posedge BOARD_CLK) begin
    if (!RESET_N) begin
      state      <= IDLE;
      px         <= '0;
      py         <= '0;
      tile_id    <= 1'b0;
      x_off      <= '0;
      y_off      <= '0;
      frame_sel  <= 1'b0;
      pending    <= 1'b0;
      rd_addr    <= '0;
      sram_addr  <= '0;
      dq_out     <= '0;
      dq_oe      <= 1'b0;
      clip_q     <= 1'b0;
      we_n       <= 1'b1;
      oe_n       <= 1'b1;
      done       <= 1'b1;
      data_ready <= 1'b0;
      data_q     <= '0;
    end else begin
      data_ready <= 1'b0;
      if (bus.queueRead) begin
        pending <= 1'b1;
        rd_addr <= bus.framebufferAddress;
      end
      case (state)
        IDLE: begin
          if (rd_req) begin
            sram_addr <= rd_sel_addr;
            oe_n      <= 1'b0;
            dq_oe     <= 1'b0;
            state     <= RD_ADDR;
          end else if (bus.streamTileTrigger) begin
            tile_id   <= bus.streamingTileID;
            x_off     <= bus.xOffset;
            y_off     <= bus.yOffset;
            frame_sel <= bus.frameSel;
            px        <= '0;
            py        <= '0;
            done      <= 1'b0;
            sram_addr <= t_addr;
            dq_out    <= t_data;
            dq_oe     <= !t_clip;
            clip_q    <= t_clip;
            state     <= WR_SETUP;
          end
        end
        WR_SETUP, WR_PULSE: begin
          if (state == WR_SETUP && !clip_q) begin
            we_n  <= 1'b0;
            state <= WR_PULSE;
          end else begin
            // pixel finished (written or clipped): pick what comes next
            we_n <= 1'b1;
            if (last_pix) begin
              dq_oe <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              px <= nxt_x;
              py <= nxt_y;
              if (rd_req) begin
                sram_addr <= rd_sel_addr;
                oe_n      <= 1'b0;
                dq_oe     <= 1'b0;
                state     <= RD_ADDR;
              end else begin
                sram_addr <= t_addr;
                dq_out    <= t_data;
                dq_oe     <= !t_clip;
                clip_q    <= t_clip;
                state     <= WR_SETUP;
              end
            end
          end
        end
        RD_ADDR: state <= RD_CAPTURE;
        RD_CAPTURE: begin
          data_q     <= SRAM_DQ;
          data_ready <= 1'b1;
          pending    <= bus.queueRead;
          oe_n       <= 1'b1;
          if (!done) begin
            sram_addr <= t_addr;
            dq_out    <= t_data;
            dq_oe     <= !t_clip;
            clip_q    <= t_clip;
            state     <= WR_SETUP;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SRAM_DQ           = dq_oe ? dq_out : 16'bz;
  assign bus.SRAM_ADDR     = sram_addr;
  assign bus.SRAM_WE_N     = we_n;
  assign bus.SRAM_OE_N     = oe_n;
  assign bus.SRAM_CE_N     = 1'b0;
  assign bus.SRAM_UB_N     = 1'b0;
  assign bus.SRAM_LB_N     = 1'b0;
  assign bus.DataFromSRAM  = data_q;
  assign bus.DataReady     = data_ready;
  assign bus.doneStreaming = done;

endmodule
`default_nettype wire
